rr_instr_sequencer: RTL and testbench
=====================================

Name: rr_instr_sequencer

Overview:
- Hardwired control unit for register-register ALU instructions on the bus-based datapath.
- Replaces hand-sequenced T0..T5 control with a parametrised FSM: fetch, decode, operand staging, ALU strobe, write-back.
- Adds a memory wait-state handshake, a MUL/DIV two-word write-back mode (LO/HI), and illegal-opcode trapping.
- Drives only datapath control strobes; it consumes the IR contents and owns no data path.

Parameters:
- DATA_W, 32, IR width; opcode at [DATA_W-1 -: OP_W].
- OP_W, 5, opcode field width.
- REG_W, 4, register-select field width; NREGS = 2**REG_W.
- Field layout: ra = next REG_W bits below the opcode, then rb, then rc.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-low reset.
- start  in  1  begin instruction fetch when idle.
- mem_ready  in  1  memory read data valid.
- ir  in  DATA_W  IR register output.
- busy  out  1  high from T0 through final state.
- done  out  1  one-cycle pulse in final state.
- illegal  out  1  one-cycle pulse on unsupported opcode.
- PCout, PCin, IncPC, MARin  out  1 each  PC/MAR strobes.
- Read, MDRin, MDRout, IRin  out  1 each  memory/IR strobes.
- Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  ALU-side strobes.
- alu_op  out  OP_W  ALU function.
- alu_go  out  1  ALU operation strobe.
- Rout  out  NREGS  one-hot register-to-bus enable.
- Rin  out  NREGS  one-hot register load enable.

Behaviour:
- Reset (clear=0, async): state IDLE; every output 0, including alu_op, Rout and Rin.
- All outputs are Moore (registered state decode); at most one bus driver is active per cycle.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHRA, 6 SHL, 7 ROR, 8 ROL, 9 MUL, 10 DIV. All others are illegal.
- IDLE: start=1 -> T0; otherwise stay.
- T0: PCout, MARin, IncPC, Zin, alu_go, alu_op=0 (ADD) -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stay in T1 while mem_ready=0, holding Read/MDRin, and asserting PCin only on the first T1 cycle.
  - Exit to T2 on mem_ready=1.
- T2: MDRout, IRin -> T3.
- T3: decode ir.
  - Illegal opcode: illegal=1, no other strobes, -> IDLE (no done).
  - Otherwise: Rout[rb], Yin -> T4.
- T4: Rout[rc], alu_op=opcode, alu_go, Zin -> T5.
- T5:
  - Normal op: Zlowout, Rin[ra], done -> T_END.
  - MUL/DIV: Zlowout, LOin -> T6.
- T6 (MUL/DIV only): Zhighout, HIin, done -> T_END.
- T_END (0-cycle decision, folded into the final state's next-state logic): start=1 -> T0 back-to-back, else IDLE.
- Outside T4, alu_op = 0.
- ra=rb=rc is legal: reads and writes are in different cycles.
- Latency with mem_ready already high:
  - start to done: 6 cycles for normal ops, 7 for MUL/DIV.
  - Each mem_ready=0 cycle adds 1.
- start is ignored while busy.
- clear asserted in any state aborts immediately: outputs 0, and no partial write strobe remains.

Test Plan:
- AND R1,R2,R3 (ir = opcode 2, ra=1, rb=2, rc=3), mem_ready=1 -> per-cycle strobes:
  - T3 Rout=0x0004 with Yin.
  - T4 Rout=0x0008, alu_op=2.
  - T5 Rin=0x0002 with done.
  - busy high 6 cycles.
- MUL R0,R5,R6 (opcode 9) -> T5 Zlowout+LOin, T6 Zhighout+HIin+done, Rin never nonzero, 7 cycles.
- mem_ready low for 3 cycles in T1 -> Read/MDRin held 4 cycles, PCin exactly once, done at cycle 9.
- Opcode 31 -> illegal pulse in T3, no Rin/Yin/Zin after T2, returns to IDLE, done never asserted.
- start held high across two ADD instructions -> second T0 immediately follows first T5, no IDLE gap.
- clear low mid-T4 -> all outputs 0 asynchronously, IDLE after release, next start fetches normally.

Source files
------------

// File: rtl/rr_instr_sequencer.sv
// rr_instr_sequencer: hardwired control FSM for register-register ALU ops.
// Fetch, decode, operand staging, ALU strobe and (LO/HI) write-back.
module rr_instr_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5,
  parameter int REG_W  = 4,
  localparam int NREGS = 2 ** REG_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              PCout,
  output logic              PCin,
  output logic              IncPC,
  output logic              MARin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              LOin,
  output logic              HIin,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_go,
  output logic [NREGS-1:0]  Rout,
  output logic [NREGS-1:0]  Rin
);

  localparam int OP_LSB = DATA_W - OP_W;
  localparam int RA_LSB = OP_LSB - REG_W;
  localparam int RB_LSB = RA_LSB - REG_W;
  localparam int RC_LSB = RB_LSB - REG_W;

  localparam logic [OP_W-1:0] OP_MUL = OP_W'(9);
  localparam logic [OP_W-1:0] OP_DIV = OP_W'(10);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T1W, S_T2,
    S_T3, S_T4, S_T5, S_T6
  } state_t;

  state_t state;

  logic [OP_W-1:0]  op;
  logic [REG_W-1:0] ra;
  logic [REG_W-1:0] rb;
  logic [REG_W-1:0] rc;
  logic             legal;
  logic             wide;
  logic             ir_unused;

  assign op        = ir[OP_LSB +: OP_W];
  assign ra        = ir[RA_LSB +: REG_W];
  assign rb        = ir[RB_LSB +: REG_W];
  assign rc        = ir[RC_LSB +: REG_W];
  assign legal     = (op <= OP_DIV);
  assign wide      = (op == OP_MUL) || (op == OP_DIV);
  assign ir_unused = ^ir[RC_LSB-1:0];

  // T1W is the wait-state copy of T1 without the PC load
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:      if (start) state <= S_T0;
        S_T0:        state <= S_T1;
        S_T1, S_T1W: state <= mem_ready ? S_T2 : S_T1W;
        S_T2:        state <= S_T3;
        S_T3:        state <= legal ? S_T4 : S_IDLE;
        S_T4:        state <= S_T5;
        S_T5: begin
          if (wide)       state <= S_T6;
          else if (start) state <= S_T0;
          else            state <= S_IDLE;
        end
        S_T6:        state <= start ? S_T0 : S_IDLE;
        default:     state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state != S_IDLE);
    done     = 1'b0;
    illegal  = 1'b0;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    alu_op   = '0;
    alu_go   = 1'b0;
    Rout     = '0;
    Rin      = '0;
    unique case (state)
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zin    = 1'b1;
        alu_go = 1'b1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      S_T1W: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (legal) begin
          Rout = NREGS'(1) << rb;
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin
        Rout   = NREGS'(1) << rc;
        alu_op = op;
        alu_go = 1'b1;
        Zin    = 1'b1;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (wide) begin
          LOin = 1'b1;
        end else begin
          Rin  = NREGS'(1) << ra;
          done = 1'b1;
        end
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rr_instr_sequencer.sv
// tb_rr_instr_sequencer: per-cycle expected strobe script built from the
// instruction timing rules, randomized instructions and wait states.
module tb_rr_instr_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        pc_out;
    logic        pc_in;
    logic        inc_pc;
    logic        mar_in;
    logic        rd;
    logic        mdr_in;
    logic        mdr_out;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        zlo_out;
    logic        zhi_out;
    logic        lo_in;
    logic        hi_in;
    logic [4:0]  alu_op;
    logic        alu_go;
    logic [15:0] rout;
    logic [15:0] rin;
  } ov_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = '0;

  logic busy, done, illegal;
  logic PCout, PCin, IncPC, MARin;
  logic Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [4:0]  alu_op;
  logic        alu_go;
  logic [15:0] Rout, Rin;

  ov_t dut_o;

  int n_chk  = 0;
  int n_fail = 0;

  bit          q_s[$];
  bit          q_r[$];
  logic [31:0] q_i[$];
  ov_t         q_e[$];
  ov_t         obs[$];

  rr_instr_sequencer dut (
    .clock(clock), .clear(clear), .start(start),
    .mem_ready(mem_ready), .ir(ir),
    .busy(busy), .done(done), .illegal(illegal),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .LOin(LOin), .HIin(HIin), .alu_op(alu_op), .alu_go(alu_go),
    .Rout(Rout), .Rin(Rin)
  );

  assign dut_o = {busy, done, illegal, PCout, PCin, IncPC, MARin,
                  Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                  Zhighout, LOin, HIin, alu_op, alu_go, Rout, Rin};

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input bit s, input bit r, input logic [31:0] i,
                      input ov_t e);
    q_s.push_back(s);
    q_r.push_back(r);
    q_i.push_back(i);
    q_e.push_back(e);
  endtask

  function automatic bit rb1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) push(1'b0, rb1(), $urandom, '0);
  endtask

  // Expected strobes of one instruction; t0 = script index of its T0.
  task automatic add_instr(input logic [31:0] irv, input int w,
                           input bit launch, input bit chain,
                           output int t0);
    ov_t        e;
    logic [4:0] op;
    bit         legal, md;
    op    = irv[31:27];
    legal = (op <= 5'd10);
    md    = (op == 5'd9) || (op == 5'd10);
    if (launch) push(1'b1, rb1(), $urandom, '0);
    t0 = q_e.size();
    e = '0; e.busy = 1; e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1;
    e.z_in = 1; e.alu_go = 1;
    push(rb1(), rb1(), $urandom, e);
    for (int k = 0; k <= w; k++) begin
      e = '0; e.busy = 1; e.rd = 1; e.mdr_in = 1;
      if (k == 0) begin e.pc_in = 1; e.zlo_out = 1; end
      push(rb1(), (k == w), $urandom, e);
    end
    e = '0; e.busy = 1; e.mdr_out = 1; e.ir_in = 1;
    push(rb1(), rb1(), $urandom, e);
    e = '0; e.busy = 1;
    if (legal) begin
      e.rout = 16'(1) << irv[22:19];
      e.y_in = 1;
    end else begin
      e.illegal = 1;
    end
    push(rb1(), rb1(), irv, e);
    if (!legal) return;
    e = '0; e.busy = 1; e.rout = 16'(1) << irv[18:15];
    e.alu_op = op; e.alu_go = 1; e.z_in = 1;
    push(rb1(), rb1(), irv, e);
    e = '0; e.busy = 1; e.zlo_out = 1;
    if (md) e.lo_in = 1;
    else begin e.rin = 16'(1) << irv[26:23]; e.done = 1; end
    push(md ? rb1() : chain, rb1(), irv, e);
    if (md) begin
      e = '0; e.busy = 1; e.zhi_out = 1; e.hi_in = 1; e.done = 1;
      push(chain, rb1(), irv, e);
    end
  endtask

  task automatic run_script();
    int bus;
    obs.delete();
    for (int i = 0; i < q_e.size(); i++) begin
      @(posedge clock); #1;
      start = q_s[i];
      mem_ready = q_r[i];
      ir = q_i[i];
      @(negedge clock);
      chk($sformatf("cyc%0d", i), 64'(dut_o), 64'(q_e[i]));
      bus = int'(dut_o.pc_out) + int'(dut_o.mdr_out) +
            int'(dut_o.zlo_out) + int'(dut_o.zhi_out) +
            $countones(dut_o.rout);
      chk($sformatf("bus_drv%0d", i), 64'(bus <= 1), 64'(1));
      obs.push_back(dut_o);
    end
    q_s.delete(); q_r.delete(); q_i.delete(); q_e.delete();
  endtask

  function automatic int cnt_busy(input int a, input int b);
    int c = 0;
    for (int k = a; k <= b; k++) c += int'(obs[k].busy);
    return c;
  endfunction

  initial begin
    int tA, tM, tW, tI, tB1, tB2, t, w, c;
    logic [31:0] irv;
    logic [4:0]  opv;
    logic [15:0] rin_or;
    bit ch, chain_prev;

    #12;
    chk("reset_outputs", 64'(dut_o), 64'(0));
    @(negedge clock);
    clear = 1'b1;

    add_idle(2);
    add_instr({5'd2, 4'd1, 4'd2, 4'd3, 15'h1a5}, 0, 1, 0, tA);
    add_idle(3);
    add_instr({5'd9, 4'd0, 4'd5, 4'd6, 15'h0f3}, 0, 1, 0, tM);
    add_idle(3);
    add_instr({5'd0, 4'd7, 4'd8, 4'd9, 15'h000}, 3, 1, 0, tW);
    add_idle(3);
    add_instr({5'd31, 4'd1, 4'd2, 4'd3, 15'h7ff}, 0, 1, 0, tI);
    add_idle(3);
    add_instr({5'd0, 4'd4, 4'd4, 4'd4, 15'h000}, 0, 1, 1, tB1);
    add_instr({5'd0, 4'd2, 4'd3, 4'd1, 15'h000}, 0, 0, 0, tB2);
    add_idle(3);
    chain_prev = 0;
    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 13);
      opv = (c > 10) ? 5'($urandom_range(11, 31)) : 5'(c);
      irv = $urandom;
      irv[31:27] = opv;
      w = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      ch = (opv <= 5'd10) && rb1() && (n < 39);
      add_instr(irv, w, !chain_prev, ch, t);
      if (!ch) add_idle($urandom_range(0, 2));
      chain_prev = ch;
    end
    add_idle(2);
    run_script();

    chk("and_t3_rout", 64'(obs[tA+3].rout), 64'h0004);
    chk("and_t3_yin", 64'(obs[tA+3].y_in), 64'(1));
    chk("and_t4_rout", 64'(obs[tA+4].rout), 64'h0008);
    chk("and_t4_aluop", 64'(obs[tA+4].alu_op), 64'(2));
    chk("and_t5_rin", 64'(obs[tA+5].rin), 64'h0002);
    chk("and_t5_done", 64'(obs[tA+5].done), 64'(1));
    chk("and_busy_cycles", 64'(cnt_busy(tA-1, tA+7)), 64'(6));
    chk("mul_t5", 64'({obs[tM+5].zlo_out, obs[tM+5].lo_in}), 64'(3));
    chk("mul_t6", 64'({obs[tM+6].zhi_out, obs[tM+6].hi_in,
                       obs[tM+6].done}), 64'(7));
    rin_or = '0;
    for (int k = tM; k <= tM + 7; k++) rin_or |= obs[k].rin;
    chk("mul_rin_zero", 64'(rin_or), 64'(0));
    chk("mul_busy_cycles", 64'(cnt_busy(tM-1, tM+8)), 64'(7));
    c = 0;
    for (int k = tW; k <= tW + 9; k++) c += int'(obs[k].rd);
    chk("wait_read_cycles", 64'(c), 64'(4));
    c = 0;
    for (int k = tW; k <= tW + 9; k++) c += int'(obs[k].pc_in);
    chk("wait_pcin_once", 64'(c), 64'(1));
    chk("wait_done_cyc9", 64'(obs[tW+8].done), 64'(1));
    chk("ill_pulse", 64'(obs[tI+3].illegal), 64'(1));
    chk("ill_idle_after", 64'(obs[tI+4].busy), 64'(0));
    c = 0;
    for (int k = tI; k <= tI + 5; k++) c += int'(obs[k].done);
    chk("ill_no_done", 64'(c), 64'(0));
    chk("b2b_first_done", 64'(obs[tB1+5].done), 64'(1));
    chk("b2b_second_t0", 64'({obs[tB1+6].busy, obs[tB1+6].pc_out}),
        64'(3));

    @(posedge clock); #1;
    ir = {5'd2, 4'd1, 4'd2, 4'd3, 15'h0};
    start = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (4) @(posedge clock);
    #2;
    chk("clr_pre_t4", 64'({alu_go, Zin, Rout}), 64'({2'b11, 16'h0008}));
    clear = 1'b0;
    #1;
    chk("clr_async", 64'(dut_o), 64'(0));
    @(posedge clock); #1;
    chk("clr_hold", 64'(dut_o), 64'(0));
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    chk("clr_idle", 64'(dut_o), 64'(0));

    add_idle(1);
    add_instr({5'd1, 4'd3, 4'd1, 4'd2, 15'h0}, 1, 1, 0, t);
    add_idle(2);
    run_script();
    chk("post_clr_done", 64'(obs[t+6].done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
